// File: rtl/shifter_pkg.sv
// shifter_pkg: operation codes and decode helpers shared by the pipelined barrel shifter.
// Contents: OP_W, OP_SLL/OP_SRL/OP_SRA/OP_ROL/OP_ROR, is_right(), is_rot(), is_legal().
// Build option: SHIFTER_ROTATE_EN makes ROL/ROR legal; otherwise they decode as pass-through.
package shifter_pkg;
    localparam int OP_W = 3;
    localparam logic [OP_W-1:0] OP_SLL = 3'b000;
    localparam logic [OP_W-1:0] OP_SRL = 3'b001;
    localparam logic [OP_W-1:0] OP_SRA = 3'b011;
    localparam logic [OP_W-1:0] OP_ROL = 3'b100;
    localparam logic [OP_W-1:0] OP_ROR = 3'b101;

    function automatic logic is_right(input logic [OP_W-1:0] op);
        return op == OP_SRL || op == OP_SRA || op == OP_ROR;
    endfunction

    function automatic logic is_rot(input logic [OP_W-1:0] op);
        return op == OP_ROL || op == OP_ROR;
    endfunction

    function automatic logic is_legal(input logic [OP_W-1:0] op);
`ifdef SHIFTER_ROTATE_EN
        return op == OP_SLL || op == OP_SRL || op == OP_SRA || is_rot(op);
`else
        return op == OP_SLL || op == OP_SRL || op == OP_SRA;
`endif
    endfunction
endpackage

// File: rtl/shifter_level.sv
// shifter_level: one combinational left-shift mux level moving data by SHIFT bit positions.
// Ports: data (operand in), fill (bit shifted into the vacated low end), rot (wrap the
// bits leaving the top back into the low end; present only with SHIFTER_ROTATE_EN),
// sel (apply this level's shift), out (result).
module shifter_level #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             fill,
`ifdef SHIFTER_ROTATE_EN
    input  logic             rot,
`endif
    input  logic             sel,
    output logic [WIDTH-1:0] out
);
    logic [SHIFT-1:0] w_low;
`ifdef SHIFTER_ROTATE_EN
    assign w_low = rot ? data[WIDTH-1 -: SHIFT] : {SHIFT{fill}};
`else
    assign w_low = {SHIFT{fill}};
`endif
    assign out = sel ? {data[WIDTH-SHIFT-1:0], w_low} : data;
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: pipelined SLL/SRL/SRA(/ROL/ROR) unit with valid/ready flow and a tag.
// Ports: clk, rst (async, active high); in_valid/in_ready/in_data/in_shamt/in_op/in_tag
// (operation in); out_valid/out_ready/out_data/out_tag (result out).
// Build option: SHIFTER_ROTATE_EN adds the rotate wrap path; without it ROL/ROR pass through.
// Right shifts run through the same left-shift levels on a bit-reversed operand; each stage
// register holds the operand in that working orientation and the output un-reverses it.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [OP_W-1:0]          in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag
);
    localparam int LOG2W = $clog2(WIDTH);
    localparam int NSTG  = (LOG2W + REG_EVERY - 1) / REG_EVERY;

    logic [NSTG-1:0]  r_v;
    logic [WIDTH-1:0] r_data  [NSTG];
    logic [LOG2W-1:0] r_shamt [NSTG];
    logic [OP_W-1:0]  r_op    [NSTG];
    logic [TAG_W-1:0] r_tag   [NSTG];

    logic [NSTG-1:0]  w_load;
    logic             w_src_v     [NSTG];
    logic [WIDTH-1:0] w_src_data  [NSTG];
    logic [LOG2W-1:0] w_src_shamt [NSTG];
    logic [OP_W-1:0]  w_src_op    [NSTG];
    logic [TAG_W-1:0] w_src_tag   [NSTG];
    logic [WIDTH-1:0] w_end       [NSTG];
    logic [WIDTH-1:0] w_lin       [LOG2W];
    logic [WIDTH-1:0] w_lout      [LOG2W];
    logic [WIDTH-1:0] w_in_rev, w_out_rev;

    genvar i, s, j;

    for (j = 0; j < WIDTH; j++) begin : g_rev
        assign w_in_rev[j]  = in_data[WIDTH-1-j];
        assign w_out_rev[j] = r_data[NSTG-1][WIDTH-1-j];
    end

    for (s = 0; s < NSTG; s++) begin : g_src
        if (s == 0) begin : g_first
            assign w_src_v[s]     = in_valid;
            assign w_src_data[s]  = is_right(in_op) ? w_in_rev : in_data;
            assign w_src_shamt[s] = in_shamt;
            assign w_src_op[s]    = in_op;
            assign w_src_tag[s]   = in_tag;
        end else begin : g_next
            assign w_src_v[s]     = r_v[s-1];
            assign w_src_data[s]  = r_data[s-1];
            assign w_src_shamt[s] = r_shamt[s-1];
            assign w_src_op[s]    = r_op[s-1];
            assign w_src_tag[s]   = r_tag[s-1];
        end
        assign w_end[s] = w_lout[((s + 1) * REG_EVERY > LOG2W ? LOG2W : (s + 1) * REG_EVERY) - 1];
    end

    for (i = 0; i < LOG2W; i++) begin : g_lvl
        localparam int S = i / REG_EVERY;
        if (i % REG_EVERY == 0) begin : g_head
            assign w_lin[i] = w_src_data[S];
        end else begin : g_chain
            assign w_lin[i] = w_lout[i-1];
        end
        // In the working orientation bit 0 always holds the original sign bit, so it is the SRA fill.
        shifter_level #(.WIDTH(WIDTH), .SHIFT(1 << i)) u_lvl (
            .data (w_lin[i]),
            .fill (w_src_op[S] == OP_SRA && w_lin[i][0]),
`ifdef SHIFTER_ROTATE_EN
            .rot  (is_rot(w_src_op[S])),
`endif
            .sel  (is_legal(w_src_op[S]) && w_src_shamt[S][i]),
            .out  (w_lout[i])
        );
    end

    // Stage k can load unless it and every stage after it is full while the output is stalled.
    always_comb begin
        w_load = '0;
        for (int k = 0; k < NSTG; k++)
            w_load[k] = out_ready || ~&(r_v | NSTG'((1 << k) - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
            for (int k = 0; k < NSTG; k++) begin
                r_data[k]  <= '0;
                r_shamt[k] <= '0;
                r_op[k]    <= '0;
                r_tag[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NSTG; k++) begin
                if (w_load[k]) begin
                    r_v[k]     <= w_src_v[k];
                    r_data[k]  <= w_end[k];
                    r_shamt[k] <= w_src_shamt[k];
                    r_op[k]    <= w_src_op[k];
                    r_tag[k]   <= w_src_tag[k];
                end
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_v[NSTG-1];
    assign out_data  = is_right(r_op[NSTG-1]) ? w_out_rev : r_data[NSTG-1];
    assign out_tag   = r_tag[NSTG-1];
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed vector table plus stream, stall and reset sequences.
module tb_pipelined_barrel_shifter;
    localparam int NSTG = 3;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  sh;
        logic [2:0]  op;
        logic [3:0]  tag;
        logic [31:0] exp;
        string       name;
    } vec_t;

    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] in_data = 0;
    logic [4:0]  in_shamt = 0;
    logic [2:0]  in_op = 0;
    logic [3:0]  in_tag = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [31:0] out_data;
    logic [3:0]  out_tag;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_out = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    bit mon_en = 0;
    logic [31:0] q_data[$];
    logic [3:0]  q_tag[$];
    vec_t vecs[14];

    pipelined_barrel_shifter #(.WIDTH(32), .REG_EVERY(2), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every output transfer must match the oldest accepted operation.
    always @(negedge clk) begin
        #2;
        if (mon_en && !rst && out_valid && out_ready) begin
            if (q_data.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got %h expected no result", out_data);
            end else begin
                check("sb_data", out_data, q_data.pop_front());
                check("sb_tag", 32'(out_tag), 32'(q_tag.pop_front()));
                if (n_out == 0) first_cyc = cyc;
                last_cyc = cyc;
                n_out++;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [4:0] sh, input logic [2:0] op,
                        input logic [3:0] tag, input logic [31:0] exp);
        int n = 0;
        @(negedge clk);
        in_valid = 1; in_data = a; in_shamt = sh; in_op = op; in_tag = tag;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (in_ready) begin
            q_data.push_back(exp);
            q_tag.push_back(tag);
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        out_ready = 1;
        send(v.a, v.sh, v.op, v.tag, v.exp);
        q_data.delete();
        q_tag.delete();
        @(posedge clk);
        #1;
        in_valid = 0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({v.name, "_lat"}, 32'(n), 32'(NSTG));
        check({v.name, "_data"}, out_data, v.exp);
        check({v.name, "_tag"}, 32'(out_tag), 32'(v.tag));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int want);
        int n = 0;
        while (q_data.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain_empty", 32'(q_data.size()), 0);
        check("drain_count", 32'(n_out), 32'(want));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int acc, hold_err, stale;
        bit have_hold;
        logic [31:0] hold;
        logic [3:0]  hold_tag;

        vecs[0]  = '{32'h0000_0001, 5'd31, 3'b000, 4'h5, 32'h8000_0000, "sll31"};
        vecs[1]  = '{32'h8000_0000, 5'd4,  3'b011, 4'h6, 32'hF800_0000, "sra4"};
        vecs[2]  = '{32'h8000_0000, 5'd4,  3'b001, 4'h7, 32'h0800_0000, "srl4"};
`ifdef SHIFTER_ROTATE_EN
        vecs[3]  = '{32'h0000_00F1, 5'd4,  3'b101, 4'h8, 32'h1000_000F, "ror4"};
        vecs[4]  = '{32'h8000_0001, 5'd1,  3'b100, 4'h9, 32'h0000_0003, "rol1"};
        vecs[5]  = '{32'h0000_0001, 5'd1,  3'b101, 4'hA, 32'h8000_0000, "ror1"};
`else
        vecs[3]  = '{32'h0000_00F1, 5'd4,  3'b101, 4'h8, 32'h0000_00F1, "ror4"};
        vecs[4]  = '{32'h8000_0001, 5'd1,  3'b100, 4'h9, 32'h8000_0001, "rol1"};
        vecs[5]  = '{32'h0000_0001, 5'd1,  3'b101, 4'hA, 32'h0000_0001, "ror1"};
`endif
        vecs[6]  = '{32'hDEAD_BEEF, 5'd0,  3'b000, 4'hB, 32'hDEAD_BEEF, "sll0"};
        vecs[7]  = '{32'h8123_4567, 5'd0,  3'b011, 4'hC, 32'h8123_4567, "sra0"};
        vecs[8]  = '{32'h1234_5678, 5'd5,  3'b111, 4'hD, 32'h1234_5678, "ill111"};
        vecs[9]  = '{32'h1234_5678, 5'd3,  3'b010, 4'hE, 32'h1234_5678, "ill010"};
        vecs[10] = '{32'h7FFF_FFFF, 5'd31, 3'b011, 4'hF, 32'h0000_0000, "sra31pos"};
        vecs[11] = '{32'hFFFF_0000, 5'd16, 3'b011, 4'h1, 32'hFFFF_FFFF, "sra16neg"};
        vecs[12] = '{32'hFFFF_FFFF, 5'd31, 3'b001, 4'h2, 32'h0000_0001, "srl31"};
        vecs[13] = '{32'hA5A5_A5A5, 5'd8,  3'b000, 4'h3, 32'hA5A5_A500, "sll8"};

        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", 32'(out_tag), 0);
        repeat (2) @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);

        for (int v = 0; v < 14; v++) run_vec(vecs[v]);

        // Back-to-back stream, one result per cycle, in order.
        mon_en = 1;
        n_out = 0;
        out_ready = 1;
        for (int k = 0; k < 16; k++) send(32'h1, 5'(k), 3'b000, 4'(k), 32'h1 << k);
        @(negedge clk);
        in_valid = 0;
        drain(16);
        check("stream_consecutive", 32'(last_cyc - first_cyc), 15);

        // Output stalled while feeding: pipeline fills, in_ready drops, output held.
        n_out = 0;
        acc = 0;
        hold_err = 0;
        have_hold = 0;
        hold = '0;
        hold_tag = '0;
        out_ready = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1; in_data = 32'h8000_0000; in_shamt = 5'(c); in_op = 3'b001; in_tag = 4'(c + 1);
            #1;
            if (in_ready) begin
                q_data.push_back(32'h8000_0000 >> c);
                q_tag.push_back(4'(c + 1));
                acc++;
            end
            if (out_valid) begin
                if (!have_hold) begin
                    hold = out_data;
                    hold_tag = out_tag;
                    have_hold = 1;
                end else if (out_data !== hold || out_tag !== hold_tag) hold_err++;
            end
        end
        check("stall_accepts", 32'(acc), 32'(NSTG));
        check("stall_hold", 32'(hold_err), 0);
        check("stall_in_ready", 32'(in_ready), 0);
        check("stall_out_valid", 32'(out_valid), 1);
        check("stall_out_data", out_data, 32'h8000_0000);
        @(negedge clk);
        out_ready = 1;
        in_valid = 1; in_data = 32'h0000_0F00; in_shamt = 5'd8; in_op = 3'b000; in_tag = 4'hC;
        #1;
        check("full_accept_emit", 32'(in_ready), 1);
        if (in_ready) begin
            q_data.push_back(32'h000F_0000);
            q_tag.push_back(4'hC);
        end
        @(negedge clk);
        in_valid = 0;
        #1;
        check("full_occupancy_kept", 32'(out_valid), 1);
        drain(NSTG + 1);

        // Reset with operations in flight.
        mon_en = 0;
        out_ready = 0;
        for (int k = 0; k < 3; k++) send(32'h0000_00FF, 5'(k + 1), 3'b000, 4'(k + 4), 32'h0);
        @(posedge clk);
        #1;
        in_valid = 0;
        check("pre_rst_out_valid", 32'(out_valid), 1);
        #2;
        rst = 1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_out_tag", 32'(out_tag), 0);
        q_data.delete();
        q_tag.delete();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 1);
        out_ready = 1;
        stale = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        check("post_rst_no_stale", 32'(stale), 0);
        run_vec(vecs[6]);
        run_vec(vecs[8]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
